// File: rtl/cache_l2a_responder.sv
`default_nettype none
// ============================================================================
// Module      : cache_l2a_responder
// Description : Direct-mapped write-back L2 serving L1a line fills, word
//               writes and line write-backs over a single-outstanding memory
//               port. Define L2_STATS_EN to add saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_l2a_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int L2_NUM_SETS   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] cache_L2a_memory_address,
    input  logic                     read_from_L2a_request,
    input  logic                     write_to_L2a_request,
    input  logic                     write_back_to_L2a_request,
    input  logic [DATA_WIDTH-1:0]    cache_write_data,
    input  logic [LINE_WIDTH-1:0]    write_back_to_L2a_data,
    output logic [LINE_WIDTH-1:0]    write_data_to_L1_from_L2,
    output logic                     L2_ready,
    output logic                     write_to_L2_verified,
    output logic                     write_back_to_L2_verified,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_read_request,
    output logic                     mem_write_request,
    output logic [LINE_WIDTH-1:0]    mem_write_data,
    input  logic [LINE_WIDTH-1:0]    mem_read_data,
    input  logic                     mem_ready
`ifdef L2_STATS_EN
    ,
    output logic [15:0]              l2_hit_count,
    output logic [15:0]              l2_miss_count
`endif
);

    localparam int c_WORDS   = LINE_WIDTH / DATA_WIDTH;
    localparam int c_WSEL_W  = $clog2(c_WORDS);
    localparam int c_IDX_W   = $clog2(L2_NUM_SETS);
    localparam int c_OFF_W   = 4;
    localparam int c_ID_W    = 2;
    localparam int c_TAG_LSB = c_OFF_W + c_IDX_W;
    localparam int c_TAG_W   = ADDRESS_WIDTH - c_ID_W - c_TAG_LSB;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_EVICT   = 3'd2,
        ST_FILL    = 3'd3,
        ST_RESPOND = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_WB    = 2'd2
    } op_t;

    state_t                  r_state;
    state_t                  w_state_next;
    op_t                     r_op;
    op_t                     w_acc_op;
    logic                    w_accept;

    logic [c_TAG_W-1:0]      r_req_tag;
    logic [c_IDX_W-1:0]      r_req_idx;
    logic [c_WSEL_W-1:0]     r_req_word;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [LINE_WIDTH-1:0]   r_wb_line;

    logic [L2_NUM_SETS-1:0]  r_valid;
    logic [L2_NUM_SETS-1:0]  r_dirty;
    logic [c_TAG_W-1:0]      r_tag_arr  [L2_NUM_SETS];
    logic [LINE_WIDTH-1:0]   r_data_arr [L2_NUM_SETS];

    logic                    r_l2_ready;
    logic                    r_wr_verified;
    logic                    r_wb_verified;
    logic [LINE_WIDTH-1:0]   r_fill_line;

    logic                    w_any_done;
    logic                    w_hit;
    logic                    w_victim_dirty;
    logic                    w_unused_addr_bits;

    assign w_any_done     = r_l2_ready | r_wr_verified | r_wb_verified;
    assign w_hit          = r_valid[r_req_idx] && (r_tag_arr[r_req_idx] == r_req_tag);
    assign w_victim_dirty = r_valid[r_req_idx] && r_dirty[r_req_idx];

    // Processor-id and byte-offset bits never take part in lookup.
    assign w_unused_addr_bits = ^{cache_L2a_memory_address[ADDRESS_WIDTH-1 -: c_ID_W],
                                  cache_L2a_memory_address[1:0]};

    assign write_data_to_L1_from_L2  = r_fill_line;
    assign L2_ready                  = r_l2_ready;
    assign write_to_L2_verified      = r_wr_verified;
    assign write_back_to_L2_verified = r_wb_verified;

    always_comb begin
        w_state_next      = r_state;
        w_accept          = 1'b0;
        w_acc_op          = OP_READ;
        mem_read_request  = 1'b0;
        mem_write_request = 1'b0;
        mem_address       = '0;
        mem_write_data    = '0;

        if (write_back_to_L2a_request) begin
            w_acc_op = OP_WB;
        end else if (write_to_L2a_request) begin
            w_acc_op = OP_WRITE;
        end

        case (r_state)
            ST_IDLE: begin
                // A pulse still high means L1a has not yet dropped the request it answers.
                if (!w_any_done && (read_from_L2a_request || write_to_L2a_request ||
                                    write_back_to_L2a_request)) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_state_next = ST_RESPOND;
                end else if (w_victim_dirty) begin
                    w_state_next = ST_EVICT;
                end else if (r_op == OP_WB) begin
                    w_state_next = ST_RESPOND;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_EVICT: begin
                mem_write_request = 1'b1;
                mem_address       = {{c_ID_W{1'b0}}, r_tag_arr[r_req_idx], r_req_idx, {c_OFF_W{1'b0}}};
                mem_write_data    = r_data_arr[r_req_idx];
                if (mem_ready) begin
                    w_state_next = (r_op == OP_WB) ? ST_RESPOND : ST_FILL;
                end
            end
            ST_FILL: begin
                mem_read_request = 1'b1;
                mem_address      = {{c_ID_W{1'b0}}, r_req_tag, r_req_idx, {c_OFF_W{1'b0}}};
                if (mem_ready) begin
                    w_state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_READ;
            r_req_tag     <= '0;
            r_req_idx     <= '0;
            r_req_word    <= '0;
            r_wdata       <= '0;
            r_wb_line     <= '0;
            r_valid       <= '0;
            r_dirty       <= '0;
            r_l2_ready    <= 1'b0;
            r_wr_verified <= 1'b0;
            r_wb_verified <= 1'b0;
            r_fill_line   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_l2_ready    <= 1'b0;
            r_wr_verified <= 1'b0;
            r_wb_verified <= 1'b0;
            r_fill_line   <= '0;

            if (w_accept) begin
                r_op       <= w_acc_op;
                r_req_tag  <= cache_L2a_memory_address[c_TAG_LSB +: c_TAG_W];
                r_req_idx  <= cache_L2a_memory_address[c_OFF_W +: c_IDX_W];
                r_req_word <= cache_L2a_memory_address[2 +: c_WSEL_W];
                r_wdata    <= cache_write_data;
                r_wb_line  <= write_back_to_L2a_data;
            end

            case (r_state)
                ST_EVICT: begin
                    if (mem_ready) begin
                        r_dirty[r_req_idx] <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (mem_ready) begin
                        r_valid[r_req_idx] <= 1'b1;
                        r_dirty[r_req_idx] <= 1'b0;
                    end
                end
                ST_RESPOND: begin
                    case (r_op)
                        OP_READ: begin
                            r_l2_ready  <= 1'b1;
                            r_fill_line <= r_data_arr[r_req_idx];
                        end
                        OP_WRITE: begin
                            r_dirty[r_req_idx] <= 1'b1;
                            r_wr_verified      <= 1'b1;
                        end
                        default: begin
                            r_valid[r_req_idx] <= 1'b1;
                            r_dirty[r_req_idx] <= 1'b1;
                            r_wb_verified      <= 1'b1;
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    // Tag/data storage has no reset; writes are suppressed on the reset edge so an aborted op leaves it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (r_state == ST_FILL && mem_ready) begin
                r_tag_arr[r_req_idx]  <= r_req_tag;
                r_data_arr[r_req_idx] <= mem_read_data;
            end else if (r_state == ST_RESPOND) begin
                if (r_op == OP_WRITE) begin
                    r_data_arr[r_req_idx][int'(r_req_word) * DATA_WIDTH +: DATA_WIDTH] <= r_wdata;
                end else if (r_op == OP_WB) begin
                    r_tag_arr[r_req_idx]  <= r_req_tag;
                    r_data_arr[r_req_idx] <= r_wb_line;
                end
            end
        end
    end

`ifdef L2_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF) begin
                    r_hit_cnt <= r_hit_cnt + 16'd1;
                end
            end else if (r_miss_cnt != 16'hFFFF) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign l2_hit_count  = r_hit_cnt;
    assign l2_miss_count = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_l2a_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_l2a_responder
// Description : Self-checking bench for cache_l2a_responder against a
//               set-array cache model plus a line-addressed memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_l2a_responder;

    localparam int c_OP_READ  = 0;
    localparam int c_OP_WRITE = 1;
    localparam int c_OP_WB    = 2;

    logic         clk;
    logic         reset;
    logic [31:0]  cache_L2a_memory_address;
    logic         read_from_L2a_request;
    logic         write_to_L2a_request;
    logic         write_back_to_L2a_request;
    logic [31:0]  cache_write_data;
    logic [127:0] write_back_to_L2a_data;
    logic [127:0] write_data_to_L1_from_L2;
    logic         L2_ready;
    logic         write_to_L2_verified;
    logic         write_back_to_L2_verified;
    logic [31:0]  mem_address;
    logic         mem_read_request;
    logic         mem_write_request;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data;
    logic         mem_ready;
`ifdef L2_STATS_EN
    logic [15:0]  l2_hit_count;
    logic [15:0]  l2_miss_count;
`endif

    cache_l2a_responder dut (
        .clk                       (clk),
        .reset                     (reset),
        .cache_L2a_memory_address  (cache_L2a_memory_address),
        .read_from_L2a_request     (read_from_L2a_request),
        .write_to_L2a_request      (write_to_L2a_request),
        .write_back_to_L2a_request (write_back_to_L2a_request),
        .cache_write_data          (cache_write_data),
        .write_back_to_L2a_data    (write_back_to_L2a_data),
        .write_data_to_L1_from_L2  (write_data_to_L1_from_L2),
        .L2_ready                  (L2_ready),
        .write_to_L2_verified      (write_to_L2_verified),
        .write_back_to_L2_verified (write_back_to_L2_verified),
        .mem_address               (mem_address),
        .mem_read_request          (mem_read_request),
        .mem_write_request         (mem_write_request),
        .mem_write_data            (mem_write_data),
        .mem_read_data             (mem_read_data),
        .mem_ready                 (mem_ready)
`ifdef L2_STATS_EN
        ,
        .l2_hit_count              (l2_hit_count),
        .l2_miss_count             (l2_miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [127:0] data;
        int           dly;
    } memop_t;

    // Reference model: cache sets, backing memory, expected memory ops.
    logic         m_valid [16];
    logic         m_dirty [16];
    logic [21:0]  m_tag   [16];
    logic [127:0] m_data  [16];
    logic [127:0] mem_model [logic [31:0]];
    memop_t       exp_q[$];
    int           m_hits;
    int           m_misses;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drop_reqs();
        read_from_L2a_request     = 1'b0;
        write_to_L2a_request      = 1'b0;
        write_back_to_L2a_request = 1'b0;
    endtask

    function automatic logic [2:0] pulses();
        return {write_back_to_L2_verified, write_to_L2_verified, L2_ready};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic quiet_check();
        bit activity;
        activity = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 0) drop_reqs();
            if (pulses() != 3'b000 || mem_read_request || mem_write_request) activity = 1'b1;
        end
        check_value("quiet_after_done", activity, 1'b0);
    endtask

    task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [127:0] wl, input bit drop_early, input bit extra);
        logic [3:0]   idx;
        logic [21:0]  tag;
        logic [1:0]   word;
        logic [31:0]  la;
        bit           hit;
        int           exp_cycles;
        logic [127:0] exp_line;
        logic [2:0]   exp_pulse;
        memop_t       cur;
        int           cycles;
        int           cnt;
        bit           done;
        bit           in_op;

        idx  = addr[7:4];
        tag  = addr[29:8];
        word = addr[3:2];
        la   = {2'b00, addr[29:4], 4'h0};
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        exp_cycles = 3;
        exp_line   = '0;
        exp_q.delete();
        if (hit) begin
            if (m_hits < 65535) m_hits++;
        end else begin
            if (m_misses < 65535) m_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                cur.wr   = 1'b1;
                cur.addr = {2'b00, m_tag[idx], idx, 4'h0};
                cur.data = m_data[idx];
                cur.dly  = int'($urandom_range(0, 3));
                exp_q.push_back(cur);
                exp_cycles += 1 + cur.dly;
                mem_model[cur.addr] = m_data[idx];
                m_dirty[idx] = 1'b0;
            end
            if (op != c_OP_WB) begin
                if (!mem_model.exists(la)) mem_model[la] = {$urandom, $urandom, $urandom, $urandom};
                cur.wr   = 1'b0;
                cur.addr = la;
                cur.data = mem_model[la];
                cur.dly  = int'($urandom_range(0, 3));
                exp_q.push_back(cur);
                exp_cycles += 1 + cur.dly;
                m_tag[idx]   = tag;
                m_valid[idx] = 1'b1;
                m_dirty[idx] = 1'b0;
                m_data[idx]  = mem_model[la];
            end
        end
        case (op)
            c_OP_READ: begin
                exp_line  = m_data[idx];
                exp_pulse = 3'b001;
            end
            c_OP_WRITE: begin
                m_data[idx][int'(word) * 32 +: 32] = wd;
                m_dirty[idx] = 1'b1;
                exp_pulse    = 3'b010;
            end
            default: begin
                m_data[idx]  = wl;
                m_tag[idx]   = tag;
                m_valid[idx] = 1'b1;
                m_dirty[idx] = 1'b1;
                exp_pulse    = 3'b100;
            end
        endcase

        // Lower-priority lines may be raised alongside; they must lose.
        cache_L2a_memory_address  = addr;
        cache_write_data          = wd;
        write_back_to_L2a_data    = wl;
        write_back_to_L2a_request = (op == c_OP_WB);
        write_to_L2a_request      = (op == c_OP_WRITE) || (extra && op == c_OP_WB);
        read_from_L2a_request     = (op == c_OP_READ) || extra;

        cycles = 0; cnt = 0; done = 1'b0; in_op = 1'b0;
        cur.dly = 0; cur.data = '0; cur.wr = 1'b0; cur.addr = '0;
        while (!done && cycles < 60) begin
            @(posedge clk); @(negedge clk);
            cycles++;
            if (drop_early && cycles == 1) drop_reqs();
            if (mem_ready) begin
                mem_ready = 1'b0;
                in_op     = 1'b0;
            end
            if (mem_read_request && mem_write_request) begin
                check_value("mem_rd_wr_exclusive", 2'b11, 2'b00);
            end else if (mem_read_request || mem_write_request) begin
                if (!in_op) begin
                    in_op = 1'b1;
                    cnt   = 0;
                    if (exp_q.size() == 0) begin
                        check_value("mem_unexpected", {mem_write_request, mem_address}, 33'h0);
                        cur.dly = 0; cur.data = '0; cur.wr = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        check_value("mem_direction", mem_write_request, cur.wr);
                        check_value("mem_address", mem_address, cur.addr);
                        if (cur.wr) check_value("evict_data", mem_write_data, cur.data);
                    end
                end
                if (cnt >= cur.dly) begin
                    mem_ready     = 1'b1;
                    mem_read_data = cur.wr ? 128'h0 : cur.data;
                end else begin
                    cnt++;
                end
            end
            if (pulses() != 3'b000) begin
                done = 1'b1;
                check_value("pulse_kind", pulses(), exp_pulse);
                check_value("latency", cycles, exp_cycles);
                if (op == c_OP_READ) check_value("fill_line", write_data_to_L1_from_L2, exp_line);
                check_value("mem_ops_left", exp_q.size(), 0);
            end
        end
        mem_ready = 1'b0;
        if (!done) check_value("completion_timeout", 1'b0, 1'b1);
        quiet_check();
    endtask

    task automatic reset_during_fill();
        bit seen;
        cache_L2a_memory_address = 32'h0000_0C50;
        read_from_L2a_request    = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); @(negedge clk);
            if (mem_read_request) seen = 1'b1;
        end
        check_value("rstfill_fill_seen", seen, 1'b1);
        check_value("rstfill_fill_addr", mem_address, 32'h0000_0C50);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check_value("rstfill_memreq", {mem_read_request, mem_write_request}, 2'b00);
        check_value("rstfill_pulses", pulses(), 3'b000);
        reset = 1'b1;
        drop_reqs();
        model_reset();
`ifdef L2_STATS_EN
        check_value("rstfill_hits", l2_hit_count, 16'd0);
        check_value("rstfill_misses", l2_miss_count, 16'd0);
`endif
        quiet_check();
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        reset = 1'b0;
        drop_reqs();
        cache_L2a_memory_address = '0;
        cache_write_data         = '0;
        write_back_to_L2a_data   = '0;
        mem_read_data            = '0;
        mem_ready                = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_ctrl", {pulses(), mem_read_request, mem_write_request}, 5'b0);
        check_value("rst_mem_addr", mem_address, 32'h0);
        check_value("rst_fill_line", write_data_to_L1_from_L2, 128'h0);
`ifdef L2_STATS_EN
        check_value("rst_hits", l2_hit_count, 16'd0);
`endif
        reset = 1'b1;

        mem_model[32'h0000_0040] = 128'hA3A2A1A0;
        run_op(c_OP_READ,  32'h0000_0040, 32'h0, 128'h0, 1'b0, 1'b0);
        run_op(c_OP_READ,  32'h0000_0040, 32'h0, 128'h0, 1'b0, 1'b0);
        run_op(c_OP_WRITE, 32'h0000_0048, 32'hDEADBEEF, 128'h0, 1'b0, 1'b0);
        run_op(c_OP_READ,  32'h0000_0440, 32'h0, 128'h0, 1'b0, 1'b0);
        run_op(c_OP_WB,    32'h0000_0080, 32'h0, 128'h1234, 1'b0, 1'b0);
        run_op(c_OP_READ,  32'h0000_0080, 32'h0, 128'h0, 1'b0, 1'b0);
        run_op(c_OP_WB,    32'hC000_0444, 32'h5, 128'h0, 1'b0, 1'b1);
        reset_during_fill();
        run_op(c_OP_READ,  32'h0000_0040, 32'h0, 128'h0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            a       = $urandom;
            a[29:8] = 22'($urandom_range(0, 2));
            op      = int'($urandom_range(0, 2));
            run_op(op, a, $urandom, {$urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

`ifdef L2_STATS_EN
        check_value("stat_hits", l2_hit_count, 16'(m_hits));
        check_value("stat_misses", l2_miss_count, 16'(m_misses));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
